uart_row_loader: RTL and testbench
==================================

# uart_row_loader

Byte-stream command parser between the controller's UART receiver and the frame-buffer RAM. It consumes the bytes the host sends at `CTRLR_CLK_TICKS_PER_BIT`: an `L` (0x4C) row-load frame, a row index, then one row of pixel bytes. It converts each frame into sequential byte writes into the frame buffer and pulses completion and error flags. It also handles a brightness command and recovers from truncated frames with an inter-byte timeout.

## Interface
Parameters:
- `PIXEL_WIDTH`, 64, pixels per row.
- `PIXEL_HEIGHT`, 32, rows in the frame buffer.
- `BYTES_PER_PIXEL`, 2, bytes per pixel.
- `TIMEOUT_TICKS`, 20'd65535, idle clocks allowed between bytes inside a frame.
- Derived `ROW_BYTES` = PIXEL_WIDTH*BYTES_PER_PIXEL.
- Derived `ADDR_W` = $clog2(PIXEL_HEIGHT*ROW_BYTES).

Ports:
- `clk_in`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `wr_en`  out  1  frame-buffer byte write strobe.
- `wr_addr`  out  ADDR_W  byte address: row*ROW_BYTES + byte index.
- `wr_data`  out  8  byte to write.
- `row_done`  out  1  one-cycle pulse when the last byte of a valid row has been written.
- `row_done_idx`  out  $clog2(PIXEL_HEIGHT)  index of the completed row; held until the next `row_done`.
- `brightness`  out  8  brightness register.
- `err`  out  1  one-cycle pulse on a protocol error.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
States: IDLE, ROW_IDX, DATA, DISCARD, BRIGHT.

- **IDLE**
  - `rx_valid` with 0x4C → ROW_IDX.
  - `rx_valid` with 0x62 (`b`) → BRIGHT.
  - Any other byte → `err` pulse; stay in IDLE.
- **ROW_IDX**
  - Byte < PIXEL_HEIGHT → latch it as the row; clear the byte counter; go to DATA.
  - Byte ≥ PIXEL_HEIGHT → `err` pulse; clear the byte counter; go to DISCARD.
- **DATA**
  - Each byte: write to `wr_addr` = row*ROW_BYTES + cnt, then increment cnt.
  - On the byte with cnt == ROW_BYTES-1: `row_done` pulses; `row_done_idx` = row; go to IDLE.
- **DISCARD**
  - Counts ROW_BYTES bytes with no writes, then returns to IDLE.
  - Does not assert `row_done`.
- **BRIGHT**
  - The next byte loads `brightness`; go to IDLE.
- **Timeout**
  - Counter clears on every `rx_valid` and increments otherwise, but only while not in IDLE.
  - When it reaches TIMEOUT_TICKS-1: `err` pulse; go to IDLE; the partial row stays written.
  - If timeout and `rx_valid` occur in the same cycle, the byte wins: the counter clears, the byte is processed, and no `err` pulse.
- **Width rules**
  - Byte counter is $clog2(ROW_BYTES+1) bits wide.
  - `wr_addr` is computed at ADDR_W width with no truncation; the highest address is PIXEL_HEIGHT*ROW_BYTES-1.

## Timing
- All outputs are registered.
- `wr_en`, `wr_addr` and `wr_data` are valid in the cycle after the `rx_valid` cycle (latency 1).
- `row_done` asserts in the same cycle as the final `wr_en`.
- `err` asserts 1 cycle after the offending byte or timeout cycle.
- `busy` changes 1 cycle after the byte that causes the transition.
- Back-to-back `rx_valid` on consecutive cycles must be accepted with no loss, which gives a sustained throughput of 1 byte/clk.
- Reset values, applied asynchronously:
  - state IDLE; all counters 0.
  - `wr_en`, `row_done`, `err`, `busy` 0.
  - `wr_addr`, `wr_data`, `row_done_idx` 0.
  - `brightness` 8'hFF.
- Reset asserted mid-frame aborts immediately. No further writes occur, and the next frame must start with 0x4C.

## Test plan
- Send 0x4C, 0x04, then 128 bytes 0x00..0x7F → `wr_addr` 512..639 with `wr_data` 0x00..0x7F; `row_done` pulses once; `row_done_idx`=4; `busy` ends at 0.
- Send 0x4C, 0x1F, 128 bytes, back-to-back every clock → 128 writes with final `wr_addr`=4095; no byte dropped.
- Send 0x4C, 0x20 (out of range), 128 bytes → `err` one pulse; zero `wr_en`; no `row_done`; a following valid frame to row 0 writes addresses 0..127.
- Send 0x4C, 0x02, 10 bytes, then silence for TIMEOUT_TICKS → 10 writes at 256..265; `err` pulse; IDLE; `busy`=0.
- Send 0x62, 0x40 → `brightness`=0x40 one cycle after the data byte. Send 0x55 in IDLE → `err` pulse with no state change.
- Assert `reset` after byte 50 of a row → outputs return to their reset values within the same cycle; `brightness`=0xFF; no writes after reset.

Source files
------------

// File: rtl/uart_row_loader.sv
// Byte-stream command parser: turns 'L' row-load frames into frame-buffer byte
// writes, handles the 'b' brightness command, and aborts stalled frames on timeout.
module uart_row_loader #(
  parameter int          PIXEL_WIDTH     = 64,
  parameter int          PIXEL_HEIGHT    = 32,
  parameter int          BYTES_PER_PIXEL = 2,
  parameter logic [19:0] TIMEOUT_TICKS   = 20'd65535,
  localparam int         ROW_BYTES       = PIXEL_WIDTH * BYTES_PER_PIXEL,
  localparam int         ADDR_W          = $clog2(PIXEL_HEIGHT * ROW_BYTES),
  localparam int         ROW_W           = $clog2(PIXEL_HEIGHT)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              row_done,
  output logic [ROW_W-1:0]  row_done_idx,
  output logic [7:0]        brightness,
  output logic              err,
  output logic              busy
);
  localparam int CNT_W = $clog2(ROW_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_BYTES - 1);
  localparam logic [7:0] CMD_ROW    = 8'h4C;
  localparam logic [7:0] CMD_BRIGHT = 8'h62;

  typedef enum logic [2:0] {IDLE, ROW_IDX, DATA, DISCARD, BRIGHT} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ROW_W-1:0]  row_q;
  logic [19:0]       tmo_q;
  logic              wr_en_q, row_done_q, err_q, busy_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q, bright_q;
  logic [ROW_W-1:0]  done_idx_q;
  logic [ADDR_W-1:0] addr_d;

  // Full-width address arithmetic so the last row's top byte never wraps.
  assign addr_d = ADDR_W'(row_q) * ADDR_W'(ROW_BYTES) + ADDR_W'(cnt_q);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      tmo_q      <= '0;
      wr_en_q    <= 1'b0;
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_idx_q <= '0;
      bright_q   <= 8'hFF;
    end else begin
      wr_en_q    <= 1'b0;
      row_done_q <= 1'b0;
      err_q      <= 1'b0;
      if (state_q == IDLE || rx_valid) tmo_q <= '0;
      else                             tmo_q <= tmo_q + 20'd1;

      if (rx_valid) begin
        case (state_q)
          IDLE: begin
            if (rx_data == CMD_ROW) begin
              state_q <= ROW_IDX;
              busy_q  <= 1'b1;
            end else if (rx_data == CMD_BRIGHT) begin
              state_q <= BRIGHT;
              busy_q  <= 1'b1;
            end else begin
              err_q   <= 1'b1;
            end
          end
          ROW_IDX: begin
            cnt_q <= '0;
            if (int'(rx_data) < PIXEL_HEIGHT) begin
              row_q   <= rx_data[ROW_W-1:0];
              state_q <= DATA;
            end else begin
              err_q   <= 1'b1;
              state_q <= DISCARD;
            end
          end
          DATA: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_d;
            wr_data_q <= rx_data;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              row_done_q <= 1'b1;
              done_idx_q <= row_q;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
            end
          end
          DISCARD: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          BRIGHT: begin
            bright_q <= rx_data;
            state_q  <= IDLE;
            busy_q   <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end else if (state_q != IDLE && tmo_q == TIMEOUT_TICKS - 20'd1) begin
        // Stalled frame: bytes already written are left in place.
        err_q   <= 1'b1;
        state_q <= IDLE;
        busy_q  <= 1'b0;
        tmo_q   <= '0;
      end
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign row_done     = row_done_q;
  assign row_done_idx = done_idx_q;
  assign brightness   = bright_q;
  assign err          = err_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_uart_row_loader.sv
// Scoreboard bench: stimulus pushes expected write/done/err events derived from
// frame-level rules; a negedge monitor pops and compares whatever the loader emits.
module tb_uart_row_loader;
  localparam int PW = 64, PH = 32, BPP = 2, RB = PW * BPP;
  localparam int TMO = 64;
  localparam int AW = $clog2(PH * RB), RW = $clog2(PH);

  logic          clk_in = 1'b0, reset = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          wr_en, row_done, err, busy;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, brightness;
  logic [RW-1:0] row_done_idx;

  uart_row_loader #(.PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .BYTES_PER_PIXEL(BPP),
                    .TIMEOUT_TICKS(20'(TMO))) dut (
    .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .row_done(row_done),
    .row_done_idx(row_done_idx), .brightness(brightness), .err(err), .busy(busy));

  always #5 clk_in = ~clk_in;

  typedef enum int {EV_WR, EV_DONE, EV_ERR} kind_t;
  typedef struct { kind_t kind; int a; int d; } ev_t;
  ev_t exp_q[$];
  int checks = 0, errors = 0;
  int m_bright = 255;
  int m_last_idx = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input kind_t k, input int a, input int d);
    ev_t e; e.kind = k; e.a = a; e.d = d; exp_q.push_back(e);
  endtask

  // Monitor: each emitted event must match the head of the expected queue.
  always @(negedge clk_in) begin
    ev_t e;
    if (!reset) begin
      if (wr_en) begin
        if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_kind", e.kind, EV_WR);
          chk("wr_addr", int'(wr_addr), e.a);
          chk("wr_data", int'(wr_data), e.d);
        end
      end
      if (row_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", e.kind, EV_DONE);
          chk("done_idx", int'(row_done_idx), e.a);
        end
      end
      if (err) begin
        if (exp_q.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("err_kind", e.kind, EV_ERR);
        end
      end
    end
  end

  // Each call leaves the caller 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk_in); #1;
    rx_valid = 1'b0; rx_data = $urandom();
    repeat (gap) begin @(posedge clk_in); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  // Full or truncated row frame; n < RB bytes means the frame times out.
  task automatic row_frame(input int row, input int n, input bit b2b);
    int base;
    logic [7:0] d;
    base = row * RB;
    if (row >= PH) push(EV_ERR, 0, 0);
    else begin
      for (int i = 0; i < n; i++) push(EV_WR, base + i, (row + i * 7) & 8'hFF);
      if (n == RB) begin push(EV_DONE, row, 0); m_last_idx = row; end
      else push(EV_ERR, 0, 0);
    end
    send(8'h4C, b2b ? 0 : rgap());
    send(8'(row), b2b ? 0 : rgap());
    for (int i = 0; i < n; i++) begin
      d = 8'((row + i * 7) & 8'hFF);
      send(d, b2b ? 0 : rgap());
    end
    if (n < RB) idle(TMO + 2);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin idle(1); budget++; end
    idle(2);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int kind, r;
    logic [7:0] v;
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bright", brightness, 8'hFF);
    chk("rst_addr", wr_addr, 0);
    @(posedge clk_in); #1; reset = 1'b0;
    idle(2);

    // Row 4 with data 0x00..0x7F.
    push(EV_DONE, 4, 0);
    exp_q.pop_back();
    for (int i = 0; i < RB; i++) push(EV_WR, 4 * RB + i, i);
    push(EV_DONE, 4, 0); m_last_idx = 4;
    send(8'h4C, 1);
    chk("busy_after_L", busy, 1);
    send(8'h04, 0);
    for (int i = 0; i < RB; i++) send(8'(i), 0);
    drain();
    chk("busy_end", busy, 0);
    chk("idx_held", row_done_idx, 4);

    // Last row, back-to-back: top address PH*RB-1.
    row_frame(PH - 1, RB, 1'b1);
    drain();
    chk("idx_last_row", row_done_idx, PH - 1);

    // Out-of-range row, then a valid row 0.
    row_frame(PH, RB, 1'b1);
    row_frame(0, RB, 1'b0);
    drain();

    // Truncated frame to row 2 times out.
    row_frame(2, 10, 1'b0);
    drain();
    chk("busy_after_tmo", busy, 0);

    // A gap of TMO-1 idle cycles: the byte arrives on the timeout cycle and wins.
    for (int i = 0; i < RB; i++) push(EV_WR, 3 * RB + i, 8'hA5 ^ i);
    push(EV_DONE, 3, 0); m_last_idx = 3;
    send(8'h4C, 0); send(8'h03, 0);
    for (int i = 0; i < RB; i++) send(8'(8'hA5 ^ i), (i == 5) ? TMO - 1 : 0);
    drain();

    // Brightness and junk byte.
    send(8'h62, 0); send(8'h40, 0);
    chk("brightness", brightness, 8'h40);
    push(EV_ERR, 0, 0);
    send(8'h55, 1);
    chk("busy_junk", busy, 0);
    drain();

    // Randomised command mix.
    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 5);
      if (kind <= 2) row_frame($urandom_range(0, PH - 1), RB, 1'b0);
      else if (kind == 3) row_frame($urandom_range(PH, 255), RB, 1'b0);
      else if (kind == 4) begin
        v = $urandom();
        send(8'h62, rgap()); send(v, 0);
        m_bright = v;
        chk("rand_bright", brightness, m_bright);
      end else begin
        do v = $urandom(); while (v == 8'h4C || v == 8'h62);
        push(EV_ERR, 0, 0);
        send(v, rgap());
      end
      drain();
      chk("rand_busy", busy, 0);
      chk("rand_idx", row_done_idx, m_last_idx);
    end

    // Reset mid-row after 50 bytes.
    r = $urandom_range(0, PH - 1);
    for (int i = 0; i < 50; i++) push(EV_WR, r * RB + i, i + 1);
    send(8'h4C, 0); send(8'(r), 0);
    for (int i = 0; i < 50; i++) send(8'(i + 1), 0);
    drain();
    rx_valid = 1'b1; rx_data = 8'h33;
    #2 reset = 1'b1; #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_bright", brightness, 8'hFF);
    chk("mid_rst_idx", row_done_idx, 0);
    chk("mid_rst_data", wr_data, 0);
    rx_valid = 1'b0;
    @(posedge clk_in); #1; reset = 1'b0;
    push(EV_ERR, 0, 0);
    send(8'h10, 0);
    for (int i = 0; i < 5; i++) begin push(EV_ERR, 0, 0); send(8'h11, 0); end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
